ce_result_packer: RTL
=====================

CE_RESULT_PACKER -- requirements
Module: ce_result_packer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the width of one result element (FP16).
REQ-002 SHALL have parameter PACK_N, default 4, meaning elements per output word; legal values 1, 2, 4, 8, 16.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of packed-word entries in the internal buffer; power of 2, at least 2.
REQ-004 SHALL have port i_clk, input, 1 bit, the clock.
REQ-005 SHALL have port i_reset_n, input, 1 bit, the reset; asynchronous, active-low.
REQ-006 SHALL have port i_tile_en, input, 1 bit, a single-cycle tile start pulse.
REQ-007 SHALL have port i_expected_count, input, 16 bits, the number of results in the tile (B*C); sampled when i_tile_en is high.
REQ-008 SHALL have ports i_in_data (input, DATA_W), i_in_valid (input, 1) and o_in_ready (output, 1), forming the result input handshake.
REQ-009 SHALL have port o_out_data, output, PACK_N*DATA_W bits; element k occupies bits [k*DATA_W +: DATA_W], and the first-accepted element is k=0.
REQ-010 SHALL have port o_out_valid, output, 1 bit, a write strobe into the downstream result FIFO.
REQ-011 SHALL have ports o_out_keep (output, PACK_N bits, lane-valid mask) and o_out_last (output, 1 bit, final word of the tile).
REQ-012 SHALL have port i_out_full, input, 1 bit, downstream FIFO full.
REQ-013 SHALL have port o_tile_done, output, 1 bit, a one-cycle completion pulse.
REQ-014 SHALL have ports o_state (output, 2 bits), o_in_count (output, 16 bits), o_out_count (output, 16 bits) and o_err_overrun (output, 1 bit, sticky), all for debug.

Function
REQ-015 SHALL implement states IDLE=0, RUN=1, DRAIN=2, DONE=3, with o_state showing the current state.
REQ-016 SHALL, in any state, on i_tile_en: clear the pack register, FIFO, lane index, o_in_count and o_out_count; latch i_expected_count; and go to RUN, or to DONE if the count is 0.
REQ-017 SHALL drive o_in_ready = (state==RUN) and (FIFO occupancy < FIFO_DEPTH), combinationally, ignoring a same-cycle pop.
REQ-018 SHALL accept an element on i_in_valid & o_in_ready: write it to the pack lane given by the lane index, then increment the lane index and o_in_count.
REQ-019 SHALL, at the same clock edge, push the assembled word (including the new element) into the FIFO when the lane index equals PACK_N-1 or o_in_count+1 equals the expected count.
REQ-020 SHALL give each pushed word a keep mask of filled lanes (low bits set contiguously) and zero data in unfilled lanes.
REQ-021 SHALL set last=1 on the pushed word only when that word completes the expected count.
REQ-022 SHALL reset the lane index to 0 after each push.
REQ-023 SHALL go from RUN to DRAIN at the edge that pushes the last word.
REQ-024 SHALL update the registered output each cycle: if the FIFO is non-empty and i_out_full=0, pop the head into o_out_data/keep/last, set o_out_valid=1 and increment o_out_count; otherwise o_out_valid=0 and the data holds.
REQ-025 SHALL have a latency of 1 cycle from the accepting edge of a word-completing element to o_out_valid, provided i_out_full=0 and the FIFO was empty.
REQ-026 SHALL never drop, duplicate or reorder words while i_out_full is high; data waits in the FIFO.
REQ-027 SHALL go from DRAIN to DONE at the edge where the FIFO becomes empty after popping the last word.
REQ-028 SHALL hold DONE for exactly one cycle with o_tile_done=1, then go to IDLE.
REQ-029 SHALL set o_err_overrun on i_in_valid=1 while state is not RUN; the element is dropped and o_err_overrun clears only on reset.
REQ-030 SHALL wrap o_in_count and o_out_count modulo 2^16.
REQ-031 SHALL, when i_tile_en and i_in_valid occur in the same cycle, give the restart priority and not accept the element.

Reset
REQ-032 SHALL, while i_reset_n=0, asynchronously force: state IDLE, FIFO empty, lane index 0, o_out_data=0, o_out_keep=0, o_out_valid=0, o_out_last=0, o_tile_done=0, both counts=0, o_err_overrun=0, o_in_ready=0.
REQ-033 SHALL, on reset mid-tile, discard all buffered data; no output follows until a new i_tile_en.

Verification
REQ-034 SHALL be verified with PACK_N=4, expected=10, and 10 back-to-back elements 0x3C00+n (n=0..9) -> 3 words; keep=1111,1111,0011; last only on word 3; word 3 upper 32 bits zero; o_tile_done one cycle later.
REQ-035 SHALL be verified with FIFO_DEPTH=4, i_out_full=1 for 30 cycles, expected=20 -> o_in_ready low after 16 accepts; after release, 5 words out in order; o_out_count=5; no loss.
REQ-036 SHALL be verified with expected=0 -> no o_out_valid; o_tile_done at the cycle after i_tile_en.
REQ-037 SHALL be verified with i_in_valid pulsed in IDLE -> o_err_overrun=1 and held until reset; no output word.
REQ-038 SHALL be verified with i_tile_en after 6 of 10 elements -> counts zero; a fresh 10-element tile yields exactly 3 words; no stale lanes.
REQ-039 SHALL be verified with i_reset_n asserted during DRAIN with 2 words buffered -> all outputs at reset values immediately; nothing emitted after release.

Source files
------------

// File: rtl/ce_result_packer.sv
`default_nettype none
// ============================================================================
// Module   : ce_result_packer
// Purpose  : Packs a tile of DATA_W results into PACK_N-lane words, buffers
//            them, and emits keep/last-tagged words to the downstream FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ce_result_packer #(
    parameter int DATA_W     = 16,
    parameter int PACK_N     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_tile_en,
    input  logic [15:0]              i_expected_count,
    input  logic [DATA_W-1:0]        i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic [PACK_N*DATA_W-1:0] o_out_data,
    output logic                     o_out_valid,
    output logic [PACK_N-1:0]        o_out_keep,
    output logic                     o_out_last,
    input  logic                     i_out_full,
    output logic                     o_tile_done,
    output logic [1:0]               o_state,
    output logic [15:0]              o_in_count,
    output logic [15:0]              o_out_count,
    output logic                     o_err_overrun
);

    localparam int c_lane_w = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int c_word_w = PACK_N * DATA_W;
    localparam int c_ent_w  = c_word_w + PACK_N + 1;
    localparam int c_ptr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_occ_w  = c_ptr_w + 1;
    localparam logic [c_lane_w-1:0] c_lane_max = c_lane_w'(PACK_N - 1);
    localparam logic [c_occ_w-1:0]  c_occ_full = c_occ_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [c_word_w-1:0]    pack_q, pack_d;
    logic [c_lane_w-1:0]    lane_q, lane_d;
    logic [15:0]            in_count_q, in_count_d;
    logic [15:0]            out_count_q, out_count_d;
    logic [15:0]            expected_q, expected_d;
    logic [c_ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]     rd_ptr_q, rd_ptr_d;
    logic [c_occ_w-1:0]     occ_q, occ_d;
    logic [c_ent_w-1:0]     mem_q [FIFO_DEPTH];
    logic [c_ent_w-1:0]     mem_d [FIFO_DEPTH];
    logic [c_word_w-1:0]    out_data_q, out_data_d;
    logic [PACK_N-1:0]      out_keep_q, out_keep_d;
    logic                   out_last_q, out_last_d;
    logic                   out_valid_q, out_valid_d;
    logic                   err_q, err_d;

    logic                   w_accept;
    logic                   w_cnt_last;
    logic                   w_push;
    logic                   w_pop;
    logic [c_word_w-1:0]    w_word;
    logic [PACK_N-1:0]      w_keep;

    assign o_in_ready    = (state_q == RUN) && (occ_q != c_occ_full);
    // Restart wins over a same-cycle element.
    assign w_accept      = i_in_valid && o_in_ready && !i_tile_en;
    assign w_cnt_last    = ((in_count_q + 16'd1) == expected_q);
    assign w_push        = w_accept && ((lane_q == c_lane_max) || w_cnt_last);
    assign w_pop         = (occ_q != '0) && !i_out_full;

    assign o_out_data    = out_data_q;
    assign o_out_keep    = out_keep_q;
    assign o_out_last    = out_last_q;
    assign o_out_valid   = out_valid_q;
    assign o_tile_done   = (state_q == DONE);
    assign o_state       = state_q;
    assign o_in_count    = in_count_q;
    assign o_out_count   = out_count_q;
    assign o_err_overrun = err_q;

    // Lanes above the current one stay zero because pack_q is cleared on push.
    always_comb begin
        w_word = pack_q;
        w_keep = '0;
        for (int k = 0; k < PACK_N; k++) begin
            if (k == int'(lane_q)) begin
                w_word[k*DATA_W +: DATA_W] = i_in_data;
            end
            if (k <= int'(lane_q)) begin
                w_keep[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        lane_d      = lane_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        expected_d  = expected_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        mem_d       = mem_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = 1'b0;
        err_d       = err_q | (i_in_valid && (state_q != RUN));

        if (i_tile_en) begin
            pack_d      = '0;
            lane_d      = '0;
            in_count_d  = '0;
            out_count_d = '0;
            expected_d  = i_expected_count;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            state_d     = (i_expected_count == 16'd0) ? DONE : RUN;
        end else begin
            if (w_accept) begin
                in_count_d = in_count_q + 16'd1;
                if (w_push) begin
                    mem_d[wr_ptr_q] = {w_cnt_last, w_keep, w_word};
                    wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
                    pack_d          = '0;
                    lane_d          = '0;
                    if (w_cnt_last) begin
                        state_d = DRAIN;
                    end
                end else begin
                    pack_d = w_word;
                    lane_d = lane_q + c_lane_w'(1);
                end
            end

            if (w_pop) begin
                {out_last_d, out_keep_d, out_data_d} = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + c_ptr_w'(1);
                out_count_d = out_count_q + 16'd1;
            end

            occ_d = occ_q + c_occ_w'(w_push) - c_occ_w'(w_pop);

            case (state_q)
                DRAIN:   if (w_pop && (occ_q == c_occ_w'(1))) state_d = DONE;
                DONE:    state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            pack_q      <= '0;
            lane_q      <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            expected_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_q      <= pack_d;
            lane_q      <= lane_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            expected_q  <= expected_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    // Storage only; validity is tracked by occ_q, so no reset is needed.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire
